// File: rtl/step_display_ctrl.sv
// Step push-button front end and 4-digit debug display for the multi-cycle CPU.
// Define STEP_AUTORUN_EN to add the run_in port and the periodic autorun stepper.
module step_display_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SCAN_CYCLES     = 100000,
   parameter int AUTORUN_CYCLES  = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_step,
   input  logic [1:0]  sw_sel,
   input  logic [31:0] pc_in,
   input  logic [2:0]  state_in,
   input  logic [2:0]  next_state_in,
   input  logic [5:0]  decode_in,
   input  logic        zero_in,
`ifdef STEP_AUTORUN_EN
   input  logic        run_in,
`endif
   output logic        step_en,
   output logic [15:0] step_count,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_CYCLES - 1);

   logic            s1_q, s2_q;
   logic            db_q, db_d;
   logic            db_dly_q;
   logic [DC_W-1:0] dcnt_q, dcnt_d;
   logic            step_en_q, step_en_d;
   logic [15:0]     step_count_q, step_count_d;
   logic [SC_W-1:0] scnt_q, scnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     snap_word_q, snap_word_d;
   logic            snap_zero_q, snap_zero_d;
   logic            auto_req;
   logic            step_req;
   logic            scan_wrap;
   logic [15:0]     page_word;
   logic [3:0]      nibble;

`ifdef STEP_AUTORUN_EN
   localparam int AC_W = (AUTORUN_CYCLES > 1) ? $clog2(AUTORUN_CYCLES) : 1;
   localparam logic [AC_W-1:0] AC_MAX = AC_W'(AUTORUN_CYCLES - 1);

   logic [AC_W-1:0] acnt_q, acnt_d;

   always_ff @(posedge clk) begin
      if (reset) acnt_q <= '0;
      else       acnt_q <= acnt_d;
   end

   // Counter parks at zero while stopped so each run starts a full period.
   always_comb begin
      auto_req = run_in && (acnt_q == AC_MAX);
      acnt_d   = '0;
      if (run_in && !auto_req) acnt_d = acnt_q + 1'b1;
   end
`else
   logic unused_autorun;
   assign unused_autorun = ^AUTORUN_CYCLES;
   assign auto_req       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         db_q         <= 1'b0;
         db_dly_q     <= 1'b0;
         dcnt_q       <= '0;
         step_en_q    <= 1'b0;
         step_count_q <= '0;
         scnt_q       <= '0;
         idx_q        <= '0;
         snap_word_q  <= '0;
         snap_zero_q  <= 1'b0;
      end else begin
         s1_q         <= btn_step;
         s2_q         <= s1_q;
         db_q         <= db_d;
         db_dly_q     <= db_q;
         dcnt_q       <= dcnt_d;
         step_en_q    <= step_en_d;
         step_count_q <= step_count_d;
         scnt_q       <= scnt_d;
         idx_q        <= idx_d;
         snap_word_q  <= snap_word_d;
         snap_zero_q  <= snap_zero_d;
      end
   end

   always_comb begin
      db_d   = db_q;
      dcnt_d = '0;
      if (s2_q != db_q) begin
         if (dcnt_q == DC_MAX) db_d = s2_q;
         else                  dcnt_d = dcnt_q + 1'b1;
      end
   end

   // Button and autorun requests merge into a single pulse and a single count.
   assign step_req     = (db_q & ~db_dly_q) | auto_req;
   assign step_en_d    = step_req;
   assign step_count_d = step_count_q + 16'(step_req);

   assign scan_wrap = (scnt_q == SC_MAX);
   assign scnt_d    = scan_wrap ? '0 : scnt_q + 1'b1;
   assign idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;

   always_comb begin
      page_word = pc_in[15:0];
      case (sw_sel)
         2'b00: page_word = pc_in[15:0];
         2'b01: page_word = pc_in[31:16];
         2'b10: page_word = {1'b0, state_in, 1'b0, next_state_in, 2'b00, decode_in};
         2'b11: page_word = step_count_q;
         default: page_word = pc_in[15:0];
      endcase
   end

   // Snapshot only at the end of a full sweep so all four digits agree.
   always_comb begin
      snap_word_d = snap_word_q;
      snap_zero_d = snap_zero_q;
      if (scan_wrap && (idx_q == 2'd3)) begin
         snap_word_d = page_word;
         snap_zero_d = zero_in;
      end
   end

   assign nibble = snap_word_q[{idx_q, 2'b00} +: 4];

   always_comb begin
      seg = 7'h40;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h40;
      endcase
   end

   assign an         = ~(4'b0001 << idx_q);
   assign dp         = ~((idx_q == 2'd0) && snap_zero_q);
   assign step_en    = step_en_q;
   assign step_count = step_count_q;

endmodule

// File: tb/tb_step_display_ctrl.sv
// Directed bench for step_display_ctrl: debounce, step pulse, count wrap, display pages, reset.
module tb_step_display_ctrl;

   localparam int DEB  = 4;
   localparam int SCAN = 2;
   localparam int AUTO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_step;
   logic [1:0]  sw_sel;
   logic [31:0] pc_in;
   logic [2:0]  state_in;
   logic [2:0]  next_state_in;
   logic [5:0]  decode_in;
   logic        zero_in;
`ifdef STEP_AUTORUN_EN
   logic        run_in;
`endif
   logic        step_en;
   logic [15:0] step_count;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int pulses;
   int first_pulse;

   always #5 clk = ~clk;

   step_display_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .SCAN_CYCLES    (SCAN),
      .AUTORUN_CYCLES (AUTO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_step     (btn_step),
      .sw_sel       (sw_sel),
      .pc_in        (pc_in),
      .state_in     (state_in),
      .next_state_in(next_state_in),
      .decode_in    (decode_in),
      .zero_in      (zero_in),
`ifdef STEP_AUTORUN_EN
      .run_in       (run_in),
`endif
      .step_en      (step_en),
      .step_count   (step_count),
      .an           (an),
      .seg          (seg),
      .dp           (dp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Advance n cycles, observing at each falling edge and tallying step pulses.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (step_en) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
         end
      end
   endtask

   task automatic start_test();
      cyc         = 0;
      pulses      = 0;
      first_pulse = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_page(input string tag, input logic [15:0] word, input logic z);
      logic [3:0] seen;
      int d;
      run_cycles(20);
      seen = '0;
      for (int i = 0; i < 4 * SCAN; i++) begin
         @(negedge clk);
         case (an)
            4'b1110: d = 0;
            4'b1101: d = 1;
            4'b1011: d = 2;
            4'b0111: d = 3;
            default: d = -1;
         endcase
         if (d >= 0) begin
            seen[d] = 1'b1;
            check($sformatf("%s_seg%0d", tag, d), {25'b0, seg}, {25'b0, hex7(word[d*4 +: 4])});
            check($sformatf("%s_dp%0d", tag, d), {31'b0, dp}, (d == 0 && z) ? 32'd0 : 32'd1);
         end
      end
      check({tag, "_digits"}, {28'b0, seen}, 32'hF);
   endtask

   initial begin
      reset         = 1'b1;
      btn_step      = 1'b0;
      sw_sel        = 2'b00;
      pc_in         = 32'h0;
      state_in      = 3'd0;
      next_state_in = 3'd0;
      decode_in     = 6'd0;
      zero_in       = 1'b0;
`ifdef STEP_AUTORUN_EN
      run_in        = 1'b0;
`endif
      @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_step_en", {31'b0, step_en}, 32'd0);
      check("rst_count", {16'b0, step_count}, 32'd0);
      check("rst_an", {28'b0, an}, 32'hE);
      check("rst_seg", {25'b0, seg}, 32'h40);
      check("rst_dp", {31'b0, dp}, 32'd1);

      // Clean press: pulse only in the cycle after edge 6
      do_reset();
      start_test();
      btn_step = 1'b1;
      run_cycles(20);
      btn_step = 1'b0;
      check("press_pulses", pulses, 32'd1);
      check("press_first", first_pulse, 32'd7);
      check("press_count", {16'b0, step_count}, 32'd1);
      run_cycles(20);
      check("release_pulses", pulses, 32'd1);
      check("release_count", {16'b0, step_count}, 32'd1);

      // Bounce: 3-cycle glitch must not register
      do_reset();
      start_test();
      btn_step = 1'b1;
      run_cycles(3);
      btn_step = 1'b0;
      run_cycles(10);
      check("glitch_pulses", pulses, 32'd0);
      btn_step = 1'b1;
      run_cycles(20);
      btn_step = 1'b0;
      run_cycles(20);
      check("bounce_pulses", pulses, 32'd1);
      check("bounce_count", {16'b0, step_count}, 32'd1);

      // Display pages
      pc_in   = 32'h89AB_CDEF;
      sw_sel  = 2'b00;
      zero_in = 1'b0;
      check_page("pg0", 16'hCDEF, 1'b0);
      sw_sel = 2'b01;
      check_page("pg1", 16'h89AB, 1'b0);
      sw_sel        = 2'b10;
      state_in      = 3'd3;
      next_state_in = 3'd5;
      decode_in     = 6'h23;
      zero_in       = 1'b1;
      check_page("pg2", 16'h3523, 1'b1);
      sw_sel = 2'b11;
      check_page("pg3", 16'h0001, 1'b1);

      // Reset during debounce, sampled at edge 3 of the press
      start_test();
      btn_step = 1'b1;
      run_cycles(3);
      reset    = 1'b1;
      btn_step = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("rdb_step_en", {31'b0, step_en}, 32'd0);
      check("rdb_count", {16'b0, step_count}, 32'd0);
      check("rdb_an", {28'b0, an}, 32'hE);
      check("rdb_seg", {25'b0, seg}, 32'h40);
      check("rdb_dp", {31'b0, dp}, 32'd1);
      run_cycles(20);
      check("rdb_pulses", pulses, 32'd0);
      check("rdb_count_after", {16'b0, step_count}, 32'd0);

      // Count wrap from 0xFFFF
      do_reset();
      force dut.step_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.step_count_q;
      @(negedge clk);
      check("wrap_preload", {16'b0, step_count}, 32'hFFFF);
      start_test();
      btn_step = 1'b1;
      run_cycles(20);
      btn_step = 1'b0;
      run_cycles(20);
      check("wrap_pulses", pulses, 32'd1);
      check("wrap_count", {16'b0, step_count}, 32'h0000);

`ifdef STEP_AUTORUN_EN
      // Autorun: one pulse every AUTO cycles
      do_reset();
      start_test();
      run_in = 1'b1;
      run_cycles(40);
      run_in = 1'b0;
      check("auto_pulses", pulses, 32'd5);
      check("auto_first", first_pulse, 32'd8);
      check("auto_count", {16'b0, step_count}, 32'd5);
      run_cycles(10);
      check("auto_stop_pulses", pulses, 32'd5);

      // Button pulse coincident with the first autorun request
      do_reset();
      start_test();
      run_in = 1'b1;
      run_cycles(1);
      btn_step = 1'b1;
      run_cycles(20);
      btn_step = 1'b0;
      run_cycles(19);
      run_in = 1'b0;
      check("coinc_first", first_pulse, 32'd8);
      check("coinc_pulses", pulses, 32'd5);
      check("coinc_count", {16'b0, step_count}, 32'd5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
